// File: rtl/lsram_pkg.sv
// Shared types and default widths for the LSRAM read-side stream controller.
package lsram_pkg;

  localparam int LSRAM_DATA_WIDTH        = 36;
  localparam int LSRAM_ADDR_WIDTH        = 9;
  localparam int LSRAM_DATA_WIDTH_NARROW = 18;
  localparam int LSRAM_ADDR_WIDTH_NARROW = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/lsram_rd_fifo2.sv
// Two-entry registered FIFO; slot0 is always the head presented downstream.
module lsram_rd_fifo2 #(
  parameter int W = 37
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop, do_push;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    do_push = push && ((count_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b10: begin
        if (count_q == 2'd0) slot0_d = din;
        else                 slot1_d = din;
        count_d = count_q + 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps the count; the new word lands behind the survivor.
        if (count_q == 2'd1) begin
          slot0_d = din;
        end else begin
          slot0_d = slot1_q;
          slot1_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign dout  = slot0_q;
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/lsram_stream_reader.sv
// Sweeps an LSRAM address range and streams the words out with ready/valid.
// Optional parity checking on rd_data is enabled by defining LSRAM_READER_PARITY_EN.
module lsram_stream_reader
  import lsram_pkg::*;
#(
  parameter int DATA_WIDTH = LSRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSRAM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  perr
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, last_addr_q, last_addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic [1:0]            fifo_count;
  logic                  fifo_valid;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic                  pop, issue;
  logic [2:0]            occupancy;

  assign pop       = fifo_valid & m_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  // A read is issued only if its word is guaranteed a FIFO slot when it returns.
  assign issue     = (state_q == READ) && (occupancy < (3'd2 + {2'b00, pop}));

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    last_addr_d     = last_addr_q;
    rem_d           = rem_q;
    done_d          = 1'b0;
    inflight_d      = issue;
    inflight_last_d = issue && (rem_q == LEN_WIDTH'(1));
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = READ;
            addr_d  = base_addr;
            rem_d   = len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          last_addr_d = addr_q;
          rem_d       = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_dout[DATA_WIDTH]) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      last_addr_q     <= '0;
      rem_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      last_addr_q     <= last_addr_d;
      rem_q           <= rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  lsram_rd_fifo2 #(
    .W(DATA_WIDTH + 1)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (inflight_q),
    .din     ({inflight_last_q, rd_data}),
    .pop     (pop),
    .dout    (fifo_dout),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

`ifdef LSRAM_READER_PARITY_EN
  logic perr_q, perr_d;

  // Even parity: the XOR of the whole word, parity bit included, must be zero.
  always_comb begin
    perr_d = perr_q | (inflight_q & (^rd_data));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) perr_q <= 1'b0;
    else          perr_q <= perr_d;
  end

  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign rd_en   = issue;
  assign rd_addr = issue ? addr_q : last_addr_q;
  assign m_valid = fifo_valid;
  assign m_data  = fifo_dout[DATA_WIDTH-1:0];
  assign m_last  = fifo_valid & fifo_dout[DATA_WIDTH];

endmodule

// File: tb/tb_lsram_stream_reader.sv
// Directed bench for lsram_stream_reader with a behavioural 512x36 synchronous RAM.
// Define LSRAM_READER_PARITY_EN on both bench and RTL to exercise the parity path.
module tb_lsram_stream_reader;

  localparam int DW = 36;
  localparam int AW = 9;
  localparam int LW = 10;

  logic          aclk;
  logic          aresetn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy, done, rd_en, m_valid, m_ready, m_last, perr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, m_data;

  logic [DW-1:0] mem [512];

  int checkCount = 0;
  int errorCount = 0;
  int cycleCnt = 0;

  logic [DW-1:0] beatData[$];
  bit            beatLast[$];
  int            beatCyc[$];
  int            addrQ[$];
  int            doneQ[$];
  int            busyCycles = 0, validCycles = 0, stableErr = 0, maxOut = 0;
  int            issued = 0, popped = 0;
  bit            stallPrev = 0;
  logic [DW-1:0] prevData;
  logic          prevLast;

  lsram_stream_reader dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .perr      (perr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cycleCnt++;

  always @(posedge aclk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  function automatic logic [DW-1:0] makeWord(input int v);
    logic [DW-2:0] p;
    p = (DW-1)'(v);
    return {^p, p};
  endfunction

  // Observes the stream at the falling edge, when everything for the coming edge is settled.
  always @(negedge aclk) begin
    if (!aresetn) begin
      issued    = 0;
      popped    = 0;
      stallPrev = 0;
    end else begin
      if (stallPrev && (!m_valid || m_data !== prevData || m_last !== prevLast)) stableErr++;
      if (rd_en) begin
        issued++;
        addrQ.push_back(int'(rd_addr));
      end
      if (m_valid && m_ready) begin
        popped++;
        beatData.push_back(m_data);
        beatLast.push_back(m_last);
        beatCyc.push_back(cycleCnt);
      end
      if (done) doneQ.push_back(cycleCnt);
      if (busy) busyCycles++;
      if (m_valid) validCycles++;
      if (issued - popped > maxOut) maxOut = issued - popped;
      stallPrev = m_valid && !m_ready;
      prevData  = m_data;
      prevLast  = m_last;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic applyStimulus(input int b, input int l, output int k);
    start     = 1'b1;
    base_addr = AW'(b);
    len       = LW'(l);
    tick();
    k     = cycleCnt;
    start = 1'b0;
  endtask

  task automatic waitDone(input int startIdx, input int budget);
    for (int i = 0; i < budget && doneQ.size() <= startIdx; i++) tick();
    checkOutput("doneSeen", 64'(doneQ.size() > startIdx), 64'd1);
  endtask

  task automatic checkBeat(input string tag, input int idx, input logic [DW-1:0] expData,
                           input bit expLast);
    logic [DW-1:0] d;
    bit            l;
    d = (idx < beatData.size()) ? beatData[idx] : 'x;
    l = (idx < beatLast.size()) ? beatLast[idx] : 1'b0;
    checkOutput({tag, "Data"}, 64'(d), 64'(expData));
    checkOutput({tag, "Last"}, 64'(l), 64'(expLast));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "Done"}, 64'(done), 64'd0);
    checkOutput({tag, "RdEn"}, 64'(rd_en), 64'd0);
    checkOutput({tag, "RdAddr"}, 64'(rd_addr), 64'd0);
    checkOutput({tag, "Valid"}, 64'(m_valid), 64'd0);
    checkOutput({tag, "Data"}, 64'(m_data), 64'd0);
    checkOutput({tag, "Last"}, 64'(m_last), 64'd0);
    checkOutput({tag, "Perr"}, 64'(perr), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, b, d, a, bc, vc;
    int expAddr[4] = '{510, 511, 0, 1};
    bit pattern[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 512; i++) mem[i] = makeWord(i);
    aresetn   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    m_ready   = 1'b1;
    repeat (3) tick();
    checkResetOutputs("reset");
    aresetn = 1'b1;
    repeat (2) tick();

    $display("[TB] base 0, len 8, m_ready held high");
    b = beatData.size();
    d = doneQ.size();
    applyStimulus(0, 8, k);
    waitDone(d, 100);
    checkOutput("t1Count", 64'(beatData.size() - b), 64'd8);
    for (int i = 0; i < 8; i++) begin
      checkBeat("t1", b + i, makeWord(i), i == 7);
      checkOutput("t1Cycle", 64'((b + i < beatCyc.size()) ? beatCyc[b + i] : -1), 64'(k + 2 + i));
    end
    checkOutput("t1DoneCycle", 64'((d < doneQ.size()) ? doneQ[d] : -1), 64'(k + 10));
    checkOutput("t1BusyAfter", 64'(busy), 64'd0);
    repeat (3) tick();

    $display("[TB] address wrap from 510, len 4");
    b = beatData.size();
    d = doneQ.size();
    a = addrQ.size();
    applyStimulus(510, 4, k);
    waitDone(d, 100);
    checkOutput("t2Count", 64'(beatData.size() - b), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2Addr", 64'((a + i < addrQ.size()) ? addrQ[a + i] : -1), 64'(expAddr[i]));
      checkBeat("t2", b + i, makeWord(expAddr[i]), i == 3);
    end
    repeat (3) tick();

    $display("[TB] len 8 with m_ready toggling and a start issued while busy");
    b = beatData.size();
    d = doneQ.size();
    applyStimulus(40, 8, k);
    for (int i = 0; i < 200 && doneQ.size() <= d; i++) begin
      m_ready = pattern[i % 4];
      if (i == 3) begin
        start     = 1'b1;
        base_addr = AW'(300);
        len       = LW'(5);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start   = 1'b0;
    m_ready = 1'b1;
    checkOutput("t3DoneSeen", 64'(doneQ.size() > d), 64'd1);
    repeat (20) tick();
    checkOutput("t3Count", 64'(beatData.size() - b), 64'd8);
    checkOutput("t3DoneCount", 64'(doneQ.size() - d), 64'd1);
    for (int i = 0; i < 8; i++) checkBeat("t3", b + i, makeWord(40 + i), i == 7);

    $display("[TB] zero-length command");
    d  = doneQ.size();
    bc = busyCycles;
    vc = validCycles;
    applyStimulus(7, 0, k);
    repeat (5) tick();
    checkOutput("t4DoneCount", 64'(doneQ.size() - d), 64'd1);
    checkOutput("t4DoneCycle", 64'((d < doneQ.size()) ? doneQ[d] : -1), 64'(k));
    checkOutput("t4Busy", 64'(busyCycles - bc), 64'd0);
    checkOutput("t4Valid", 64'(validCycles - vc), 64'd0);

    $display("[TB] reset in the middle of a len 16 transfer");
    b = beatData.size();
    d = doneQ.size();
    applyStimulus(0, 16, k);
    for (int i = 0; i < 50 && beatData.size() < b + 3; i++) tick();
    checkOutput("t5ThreeBeats", 64'(beatData.size() >= b + 3), 64'd1);
    aresetn = 1'b0;
    #1;
    checkResetOutputs("t5Reset");
    repeat (2) tick();
    aresetn = 1'b1;
    repeat (3) tick();
    checkOutput("t5NoDone", 64'(doneQ.size() - d), 64'd0);
    checkOutput("t5Idle", 64'(busy), 64'd0);
    b = beatData.size();
    applyStimulus(100, 2, k);
    waitDone(d, 100);
    checkOutput("t5Count", 64'(beatData.size() - b), 64'd2);
    checkBeat("t5First", b, makeWord(100), 1'b0);
    checkBeat("t5Second", b + 1, makeWord(101), 1'b1);
    repeat (3) tick();

`ifdef LSRAM_READER_PARITY_EN
    $display("[TB] corrupted parity on address 205");
    checkOutput("t6PerrBefore", 64'(perr), 64'd0);
    mem[205][DW-1] = ~mem[205][DW-1];
    b = beatData.size();
    d = doneQ.size();
    applyStimulus(200, 10, k);
    waitDone(d, 100);
    checkOutput("t6Perr", 64'(perr), 64'd1);
    checkOutput("t6Count", 64'(beatData.size() - b), 64'd10);
    for (int i = 0; i < 10; i++)
      checkBeat("t6", b + i,
                (i == 5) ? (makeWord(205) ^ {1'b1, {(DW-1){1'b0}}}) : makeWord(200 + i), i == 9);
    repeat (5) tick();
    checkOutput("t6PerrSticky", 64'(perr), 64'd1);
`else
    checkOutput("perrTied", 64'(perr), 64'd0);
`endif

    checkOutput("maxOutstanding", 64'(maxOut <= 2), 64'd1);
    checkOutput("stallStable", 64'(stableErr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
